// File: rtl/estendedor_pulso.sv
// Pulse stretcher: turns single-cycle events into fixed-length "on" bursts.
// Each burst is followed by a mandatory "off" gap. Extra requests wait in a saturating queue.
module estendedor_pulso #(
  parameter logic [19:0] ON_TIME  = 20'd500000,
  parameter logic [19:0] OFF_TIME = 20'd500000,
  parameter logic [3:0]  MAX_PEND = 4'd15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pulso_in,
  input  logic       limpar,
  output logic       out,
  output logic       ocupado,
  output logic [3:0] pendentes,
  output logic       overflow
);

  localparam logic [1:0] OCIOSO    = 2'd0;
  localparam logic [1:0] LIGADO    = 2'd1;
  localparam logic [1:0] INTERVALO = 2'd2;

  logic [1:0]  state;
  logic [1:0]  state_next;
  logic [19:0] count;
  logic [19:0] count_next;
  logic [3:0]  pend_next;
  logic        ovf_next;
  logic        last_on;
  logic        last_off;

  assign last_on  = (state == LIGADO)    && (count == ON_TIME - 20'd1);
  assign last_off = (state == INTERVALO) && (count == OFF_TIME - 20'd1);

  // A pulse on the final gap cycle is the pending request, even when the queue is empty.
  always_comb begin
    state_next = state;
    case (state)
      OCIOSO:    if (pulso_in) state_next = LIGADO;
      LIGADO:    if (last_on) state_next = INTERVALO;
      INTERVALO: begin
        if (last_off) begin
          if (!limpar && ((pendentes != 4'd0) || pulso_in)) state_next = LIGADO;
          else state_next = OCIOSO;
        end
      end
      default:   state_next = OCIOSO;
    endcase
  end

  // Enqueue and dequeue on the same edge cancel out, so nothing is dropped then.
  always_comb begin
    pend_next = pendentes;
    ovf_next  = overflow;
    if (limpar) begin
      pend_next = 4'd0;
      ovf_next  = 1'b0;
    end else if (state != OCIOSO) begin
      if (last_off) begin
        if ((pendentes != 4'd0) && !pulso_in) pend_next = pendentes - 4'd1;
      end else if (pulso_in) begin
        if (pendentes == MAX_PEND) ovf_next = 1'b1;
        else pend_next = pendentes + 4'd1;
      end
    end
  end

  always_comb begin
    count_next = 20'd0;
    if ((state_next == state) && (state != OCIOSO)) count_next = count + 20'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= OCIOSO;
      count     <= 20'd0;
      out       <= 1'b0;
      ocupado   <= 1'b0;
      pendentes <= 4'd0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      out       <= (state_next == LIGADO);
      ocupado   <= (state_next != OCIOSO);
      pendentes <= pend_next;
      overflow  <= ovf_next;
    end
  end

endmodule
